reaction_timer_ctrl: RTL and testbench

//  Multi-player reaction-time game controller; successor of the two-button start/stop FSM.

---
 rtl/reaction_timer_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_ctrl.sv
// Multi-player reaction-time game controller: random GO delay, tick timing, fouls, timeout.
// Ports: clock, reset (sync active-low), start, stop[NUM_PLAYERS] in;
//        lamp, timing, elapsed, winner, done, foul, timeout out.
//        Define BEST_SCORE_EN to add show_best in and best, best_valid out.
module reaction_timer_ctrl #(
   parameter int NUM_PLAYERS = 2,
   parameter int CNT_WIDTH   = 14,
   parameter int TICK_DIV    = 50000,
   parameter int MIN_DELAY   = 500,
   parameter int RND_BITS    = 11,
   parameter int WIN_W       = $clog2(NUM_PLAYERS)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [NUM_PLAYERS-1:0] stop,
`ifdef BEST_SCORE_EN
   input  logic                   show_best,
   output logic [CNT_WIDTH-1:0]   best,
   output logic                   best_valid,
`endif
   output logic                   lamp,
   output logic                   timing,
   output logic [CNT_WIDTH-1:0]   elapsed,
   output logic [WIN_W-1:0]       winner,
   output logic                   done,
   output logic                   foul,
   output logic                   timeout
);

   localparam int PW    = $clog2(TICK_DIV);
   localparam int DLY_W = $clog2(MIN_DELAY + (1 << RND_BITS)) + 1;
   localparam logic [PW-1:0]        TERM  = PW'(TICK_DIV - 1);
   localparam logic [CNT_WIDTH-1:0] E_MAX = '1;

   typedef enum logic [1:0] {IDLE, ARMED, GO, RESULT} state_t;

   state_t               state_q, state_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [PW-1:0]        presc_q, presc_d;
   logic [DLY_W-1:0]     delay_q, delay_d;
   logic [CNT_WIDTH-1:0] elapsed_q, elapsed_d;
   logic [WIN_W-1:0]     winner_q, winner_d;
   logic                 done_q, done_d;
   logic                 foul_q, foul_d;
   logic                 timeout_q, timeout_d;
   logic                 lamp_q, lamp_d;
   logic                 timing_q, timing_d;
   logic                 tick;
   logic                 any_stop;
   logic [WIN_W-1:0]     win_idx;

   // Lowest set stop bit wins; scan downwards so the last hit is the lowest.
   always_comb begin
      win_idx = '0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (stop[i]) win_idx = WIN_W'(i);
      end
   end

   assign any_stop = |stop;
   assign tick     = ((state_q == ARMED) || (state_q == GO))
                     && (presc_q == TERM);

   always_comb begin
      state_d   = state_q;
      lfsr_d    = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      delay_d   = delay_q;
      elapsed_d = elapsed_q;
      winner_d  = winner_q;
      done_d    = done_q;
      foul_d    = foul_q;
      timeout_d = timeout_q;
      presc_d   = '0;

      unique case (state_q)
         IDLE, RESULT: begin
            if (start) begin
               state_d   = ARMED;
               delay_d   = DLY_W'(MIN_DELAY)
                           + DLY_W'(lfsr_q[RND_BITS-1:0]);
               elapsed_d = '0;
               winner_d  = '0;
               done_d    = 1'b0;
               foul_d    = 1'b0;
               timeout_d = 1'b0;
            end
         end
         ARMED: begin
            if (any_stop) begin
               state_d  = RESULT;
               foul_d   = 1'b1;
               winner_d = win_idx;
            end else if (tick) begin
               // Expiry is taken on the tick that brings the count to zero.
               if (delay_q <= DLY_W'(1)) begin
                  state_d   = GO;
                  delay_d   = '0;
                  elapsed_d = '0;
               end else begin
                  delay_d = delay_q - DLY_W'(1);
               end
            end
         end
         GO: begin
            if (any_stop) begin
               state_d  = RESULT;
               done_d   = 1'b1;
               winner_d = win_idx;
            end else if (tick) begin
               if (elapsed_q == E_MAX) begin
                  state_d   = RESULT;
                  timeout_d = 1'b1;
               end else begin
                  elapsed_d = elapsed_q + CNT_WIDTH'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Prescaler runs only while staying in ARMED/GO; any entry restarts it.
      if ((state_d == state_q)
          && ((state_q == ARMED) || (state_q == GO))) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end

      lamp_d   = (state_d == GO);
      timing_d = (state_d == GO);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         lfsr_q    <= 16'hACE1;
         presc_q   <= '0;
         delay_q   <= '0;
         elapsed_q <= '0;
         winner_q  <= '0;
         done_q    <= 1'b0;
         foul_q    <= 1'b0;
         timeout_q <= 1'b0;
         lamp_q    <= 1'b0;
         timing_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         presc_q   <= presc_d;
         delay_q   <= delay_d;
         elapsed_q <= elapsed_d;
         winner_q  <= winner_d;
         done_q    <= done_d;
         foul_q    <= foul_d;
         timeout_q <= timeout_d;
         lamp_q    <= lamp_d;
         timing_q  <= timing_d;
      end
   end

   assign lamp    = lamp_q;
   assign timing  = timing_q;
   assign winner  = winner_q;
   assign done    = done_q;
   assign foul    = foul_q;
   assign timeout = timeout_q;

`ifdef BEST_SCORE_EN
   logic [CNT_WIDTH-1:0] best_q, best_d;
   logic                 bv_q, bv_d;
   logic                 newd_q, newd_d;

   // newd_q marks the first RESULT cycle of a done round; best is
   // compared against the held elapsed value one cycle later.
   always_comb begin
      best_d = best_q;
      bv_d   = bv_q;
      newd_d = (state_q != RESULT) && (state_d == RESULT) && done_d;
      if (newd_q && (!bv_q || (elapsed_q < best_q))) begin
         best_d = elapsed_q;
         bv_d   = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         best_q <= '0;
         bv_q   <= 1'b0;
         newd_q <= 1'b0;
      end else begin
         best_q <= best_d;
         bv_q   <= bv_d;
         newd_q <= newd_d;
      end
   end

   assign best       = best_q;
   assign best_valid = bv_q;
   assign elapsed    = (show_best
                        && ((state_q == IDLE) || (state_q == RESULT)))
                       ? best_q : elapsed_q;
`else
   assign elapsed = elapsed_q;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl (4 players, TICK_DIV=4, CNT_WIDTH=6).
// Inputs change #1 after a rising edge; outputs are sampled at the same point.
module tb_reaction_timer_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [3:0] stop  = 4'b0;
   logic       lamp, timing, done, foul, timeout;
   logic [5:0] elapsed;
   logic [1:0] winner;
`ifdef BEST_SCORE_EN
   logic       show_best = 1'b0;
   logic [5:0] best;
   logic       best_valid;
`endif

   int nvec = 0;
   int nerr = 0;

   reaction_timer_ctrl #(
      .NUM_PLAYERS(4), .CNT_WIDTH(6), .TICK_DIV(4),
      .MIN_DELAY(3), .RND_BITS(2)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop),
`ifdef BEST_SCORE_EN
      .show_best(show_best), .best(best), .best_valid(best_valid),
`endif
      .lamp(lamp), .timing(timing), .elapsed(elapsed),
      .winner(winner), .done(done), .foul(foul), .timeout(timeout)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_lamp(input string tag);
      int n = 0;
      while (lamp !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      check(tag, 32'(lamp), 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic play(input int ticks, input int p);
      pulse_start();
      wait_lamp("play_lamp");
      repeat (4 * ticks) step();
      stop[p] = 1'b1;
      step();
      stop = 4'b0;
   endtask

   initial begin
      int n;
      // reset held low two cycles
      step();
      step();
      check("rst_lamp", 32'(lamp), 0);
      check("rst_timing", 32'(timing), 0);
      check("rst_elapsed", 32'(elapsed), 0);
      check("rst_flags", 32'({done, foul, timeout}), 0);
      check("rst_winner", 32'(winner), 0);
      reset = 1'b1;
      step();

      // stops in IDLE do nothing
      stop = 4'b1111;
      step();
      stop = 4'b0;
      step();
      check("idle_stop", 32'({lamp, done, foul, timeout, winner}), 0);

      // normal round: player 2 stops after 5 ticks
      pulse_start();
      check("armed_lamp", 32'(lamp), 0);
      wait_lamp("r1_lamp");
      check("r1_timing", 32'(timing), 1);
      check("r1_el0", 32'(elapsed), 0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("go_start_ign", 32'(lamp), 1);
      repeat (19) step();
      check("r1_el5", 32'(elapsed), 5);
      stop[2] = 1'b1;
      step();
      stop = 4'b0;
      check("r1_done", 32'(done), 1);
      check("r1_winner", 32'(winner), 2);
      check("r1_elapsed", 32'(elapsed), 5);
      check("r1_lamp_off", 32'({lamp, timing}), 0);
      check("r1_other", 32'({foul, timeout}), 0);
      stop[0] = 1'b1;
      repeat (4) step();
      stop = 4'b0;
      check("res_stop_ign", 32'({winner, elapsed}), 32'({2'd2, 6'd5}));

      // foul: stop[1] while ARMED
      pulse_start();
      check("r2_cleared", 32'({done, foul, timeout}), 0);
      stop[1] = 1'b1;
      step();
      stop = 4'b0;
      check("r2_foul", 32'({done, foul, timeout}), 32'b010);
      check("r2_winner", 32'(winner), 1);
      check("r2_elapsed", 32'(elapsed), 0);
      n = 0;
      repeat (40) begin
         step();
         if (lamp) n++;
      end
      check("r2_no_lamp", n, 0);

      // simultaneous stops coincident with the first tick
      pulse_start();
      wait_lamp("r3_lamp");
      repeat (3) step();
      stop = 4'b1010;
      step();
      stop = 4'b0;
      check("r3_winner", 32'(winner), 1);
      check("r3_done", 32'(done), 1);
      check("r3_tick_drop", 32'(elapsed), 0);

      // timeout: no press
      pulse_start();
      wait_lamp("r4_lamp");
      n = 0;
      while (timeout !== 1'b1 && n < 400) begin
         step();
         n++;
      end
      check("r4_cycles", n, 256);
      check("r4_flags", 32'({done, foul, timeout}), 32'b001);
      check("r4_elapsed", 32'(elapsed), 63);
      check("r4_lamp", 32'(lamp), 0);
      pulse_start();
      check("r4_restart", 32'({done, foul, timeout}), 0);
      check("r4_el_clr", 32'(elapsed), 0);
      stop = 4'b0001;
      step();
      stop = 4'b0;

`ifdef BEST_SCORE_EN
      play(9, 0);
      step();
      check("b_first", 32'(best), 9);
      play(5, 3);
      step();
      play(7, 1);
      step();
      check("b_best", 32'(best), 5);
      check("b_valid", 32'(best_valid), 1);
      show_best = 1'b1;
      #1;
      check("b_show", 32'(elapsed), 5);
      show_best = 1'b0;
      #1;
      check("b_live", 32'(elapsed), 7);
`endif

      // reset mid-GO
      pulse_start();
      wait_lamp("r5_lamp");
      repeat (6) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("r5_lamp", 32'({lamp, timing}), 0);
      check("r5_result", 32'({done, foul, timeout, winner}), 0);
      check("r5_elapsed", 32'(elapsed), 0);
`ifdef BEST_SCORE_EN
      check("r5_best", 32'({best_valid, best}), 0);
`endif
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
